// File: rtl/round_robin_index_arbiter_pkg.sv
// Shared definitions for the round-robin index arbiter: FSM encodings and a
// constant-foldable ceil(log2) used to size the index and hold counter.
package round_robin_index_arbiter_pkg;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_GRANTED = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        logic [32:0] span   = 33'd1;
        while (span < 33'(value)) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/round_robin_index_arbiter_rr_priority_pick.sv
// Combinational rotating-priority pick: first set request at or after start,
// wrapping at NUM_REQ-1, found via a double-width rotate-and-scan.
module rr_priority_pick
    import round_robin_index_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned INDEX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [INDEX_WIDTH-1:0] start,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] winner
);

    logic [NUM_REQ-1:0]     rotated;
    logic [INDEX_WIDTH-1:0] offset;
    logic [INDEX_WIDTH:0]   sum;

    // Bit k of rotated is requester (start + k) mod NUM_REQ.
    assign rotated = NUM_REQ'({req, req} >> start);

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = INDEX_WIDTH'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= (INDEX_WIDTH + 1)'(NUM_REQ)) begin
            sum = sum - (INDEX_WIDTH + 1)'(NUM_REQ);
        end
        winner = sum[INDEX_WIDTH-1:0];
    end

endmodule

// File: rtl/round_robin_index_arbiter.sv
// Round-robin arbiter producing a registered binary winner index and valid flag;
// a grant is held until released by the owner or forced off by HOLD_LIMIT.
module round_robin_index_arbiter
    import round_robin_index_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned INDEX_WIDTH = clog2(NUM_REQ),
    parameter int unsigned HOLD_LIMIT  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic                   release_in,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   timeout_pulse
);

    localparam int unsigned HOLD_BITS  = clog2(HOLD_LIMIT + 1);
    localparam int unsigned HOLD_WIDTH = (HOLD_BITS > 0) ? HOLD_BITS : 1;
    localparam logic [HOLD_WIDTH-1:0]  HOLD_LAST = HOLD_WIDTH'(HOLD_LIMIT - 1);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_MAX  = '1;
    localparam logic [INDEX_WIDTH-1:0] LAST_REQ  = INDEX_WIDTH'(NUM_REQ - 1);

    logic                   state_q, state_d;
    logic [INDEX_WIDTH-1:0] rr_pointer_q, rr_pointer_d;
    logic [HOLD_WIDTH-1:0]  hold_count_q, hold_count_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   timeout_q, timeout_d;
    logic                   found;
    logic [INDEX_WIDTH-1:0] winner;
    logic [INDEX_WIDTH-1:0] next_pointer;
    logic                   limit_hit;

    rr_priority_pick #(
        .NUM_REQ    (NUM_REQ),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_pick (
        .req   (req_in),
        .start (rr_pointer_q),
        .found (found),
        .winner(winner)
    );

    assign next_pointer = (index_q == LAST_REQ) ? '0 : index_q + INDEX_WIDTH'(1);
    assign limit_hit    = (HOLD_LIMIT != 0) && (hold_count_q == HOLD_LAST);

    always_comb begin
        state_d      = state_q;
        rr_pointer_d = rr_pointer_q;
        hold_count_d = hold_count_q;
        index_d      = index_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    index_d      = winner;
                    hold_count_d = '0;
                    state_d      = ST_GRANTED;
                end
            end
            default: begin
                // An owner release wins over a simultaneous limit hit, so no pulse then.
                if (release_in || limit_hit) begin
                    rr_pointer_d = next_pointer;
                    state_d      = ST_IDLE;
                    timeout_d    = !release_in;
                end else if (hold_count_q != HOLD_MAX) begin
                    hold_count_d = hold_count_q + HOLD_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_pointer_q <= '0;
            hold_count_q <= '0;
            index_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_pointer_q <= rr_pointer_d;
            hold_count_q <= hold_count_d;
            index_q      <= index_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant_valid   = (state_q == ST_GRANTED);
    assign grant_index   = index_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_round_robin_index_arbiter.sv
// Bench for round_robin_index_arbiter: a directed vector table, hand-written
// hold-limit and three-requester sequences, then random traffic against a model.
module tb_round_robin_index_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req4;
    logic       rel4;
    logic [2:0] req3;
    logic       rel3;
    logic       v4, t4, v3, t3;
    logic [1:0] i4, i3;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = four requesters, 1 = three requesters.
    int m_valid[2];
    int m_idx[2];
    int m_ptr[2];
    int m_age[2];
    int m_to[2];

    always #5 clk = ~clk;

    round_robin_index_arbiter #(
        .NUM_REQ    (4),
        .INDEX_WIDTH(2),
        .HOLD_LIMIT (16)
    ) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_in       (req4),
        .release_in   (rel4),
        .grant_valid  (v4),
        .grant_index  (i4),
        .timeout_pulse(t4)
    );

    round_robin_index_arbiter #(
        .NUM_REQ    (3),
        .INDEX_WIDTH(2),
        .HOLD_LIMIT (5)
    ) dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_in       (req3),
        .release_in   (rel3),
        .grant_valid  (v3),
        .grant_index  (i3),
        .timeout_pulse(t3)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rel;
        int         v;
        int         idx;
        int         to;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic rst_n, input logic [3:0] req, input logic rel,
                                input int v, input int idx, input int to);
        vec_t r;
        r.rst_n = rst_n;
        r.req   = req;
        r.rel   = rel;
        r.v     = v;
        r.idx   = idx;
        r.to    = to;
        return r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Grant age counts valid cycles of the current grant; release at age == limit.
    task automatic model_step(input int d, input int n, input int lim, input logic rst_n,
                              input logic [3:0] req, input logic rel);
        bit hit;
        if (!rst_n) begin
            m_valid[d] = 0;
            m_idx[d]   = 0;
            m_ptr[d]   = 0;
            m_age[d]   = 0;
            m_to[d]    = 0;
        end else begin
            m_to[d] = 0;
            if (m_valid[d] == 0) begin
                hit = 0;
                for (int k = 0; k < n; k++) begin
                    int c;
                    c = (m_ptr[d] + k) % n;
                    if (!hit && req[c]) begin
                        hit        = 1;
                        m_idx[d]   = c;
                        m_valid[d] = 1;
                        m_age[d]   = 1;
                    end
                end
            end else if (rel) begin
                m_valid[d] = 0;
                m_ptr[d]   = (m_idx[d] + 1) % n;
            end else if (lim > 0 && m_age[d] == lim) begin
                m_valid[d] = 0;
                m_ptr[d]   = (m_idx[d] + 1) % n;
                m_to[d]    = 1;
            end else begin
                m_age[d] = m_age[d] + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, 16, reset_n, req4, rel4);
        model_step(1, 3, 5, reset_n, {1'b0, req3}, rel3);
        #1;
        check("model4 valid", int'(v4), m_valid[0]);
        check("model4 index", int'(i4), m_idx[0]);
        check("model4 timeout", int'(t4), m_to[0]);
        check("model3 valid", int'(v3), m_valid[1]);
        check("model3 index", int'(i3), m_idx[1]);
        check("model3 timeout", int'(t3), m_to[1]);
    endtask

    task automatic expect4(input string name, input int v, input int idx, input int to);
        check({name, " valid"}, int'(v4), v);
        check({name, " index"}, int'(i4), idx);
        check({name, " timeout"}, int'(t4), to);
    endtask

    int seq3_v[7];
    int seq3_i[7];

    initial begin
        reset_n = 1'b0;
        req4    = '0;
        rel4    = 1'b0;
        req3    = '0;
        rel3    = 1'b0;

        vecs[0]  = mk(1'b0, 4'b0000, 1'b0, 0, 0, 0);
        vecs[1]  = mk(1'b1, 4'b0100, 1'b0, 1, 2, 0);
        vecs[2]  = mk(1'b1, 4'b0100, 1'b1, 0, 2, 0);
        vecs[3]  = mk(1'b1, 4'b0011, 1'b0, 1, 0, 0);
        vecs[4]  = mk(1'b1, 4'b0011, 1'b1, 0, 0, 0);
        vecs[5]  = mk(1'b1, 4'b0011, 1'b0, 1, 1, 0);
        vecs[6]  = mk(1'b1, 4'b0011, 1'b1, 0, 1, 0);
        vecs[7]  = mk(1'b0, 4'b1111, 1'b0, 0, 0, 0);
        vecs[8]  = mk(1'b1, 4'b1111, 1'b0, 1, 0, 0);
        vecs[9]  = mk(1'b1, 4'b1111, 1'b1, 0, 0, 0);
        vecs[10] = mk(1'b1, 4'b1111, 1'b1, 1, 1, 0);
        vecs[11] = mk(1'b1, 4'b1111, 1'b1, 0, 1, 0);
        vecs[12] = mk(1'b1, 4'b1111, 1'b1, 1, 2, 0);
        vecs[13] = mk(1'b1, 4'b1111, 1'b1, 0, 2, 0);
        vecs[14] = mk(1'b1, 4'b1111, 1'b1, 1, 3, 0);
        vecs[15] = mk(1'b1, 4'b1111, 1'b1, 0, 3, 0);
        vecs[16] = mk(1'b1, 4'b1111, 1'b1, 1, 0, 0);
        vecs[17] = mk(1'b1, 4'b1111, 1'b0, 1, 0, 0);
        vecs[18] = mk(1'b1, 4'b1111, 1'b1, 0, 0, 0);
        vecs[19] = mk(1'b1, 4'b1000, 1'b0, 1, 3, 0);
        vecs[20] = mk(1'b1, 4'b0000, 1'b0, 1, 3, 0);
        vecs[21] = mk(1'b0, 4'b1001, 1'b0, 0, 0, 0);
        vecs[22] = mk(1'b1, 4'b1001, 1'b0, 1, 0, 0);
        vecs[23] = mk(1'b1, 4'b1001, 1'b1, 0, 0, 0);
        vecs[24] = mk(1'b1, 4'b0000, 1'b1, 0, 0, 0);
        vecs[25] = mk(1'b1, 4'b0000, 1'b0, 0, 0, 0);
        vecs[26] = mk(1'b1, 4'b1001, 1'b0, 1, 3, 0);
        vecs[27] = mk(1'b1, 4'b1001, 1'b1, 0, 3, 0);

        for (int i = 0; i < 28; i++) begin
            reset_n = vecs[i].rst_n;
            req4    = vecs[i].req;
            rel4    = vecs[i].rel;
            tick();
            expect4($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].to);
        end

        // Sole requester never releases: 16 valid cycles, pulse bubble, regrant.
        req4 = 4'b0010;
        rel4 = 1'b0;
        tick();
        expect4("hold first", 1, 1, 0);
        for (int k = 1; k < 16; k++) begin
            tick();
            expect4($sformatf("hold cycle%0d", k), 1, 1, 0);
        end
        tick();
        expect4("hold forced", 0, 1, 1);
        tick();
        expect4("hold regrant", 1, 1, 0);
        rel4 = 1'b1;
        tick();
        expect4("hold release", 0, 1, 0);
        req4 = '0;
        rel4 = 1'b0;

        // Three requesters, release every granted cycle.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req3    = 3'b111;
        rel3    = 1'b1;
        seq3_v  = '{1, 0, 1, 0, 1, 0, 1};
        seq3_i  = '{0, 0, 1, 1, 2, 2, 0};
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("n3 step%0d valid", k), int'(v3), seq3_v[k]);
            check($sformatf("n3 step%0d index", k), int'(i3), seq3_i[k]);
        end
        req3 = '0;
        rel3 = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            req4    = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            rel4    = ($urandom_range(0, 5) == 0);
            req3    = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            rel3    = ($urandom_range(0, 3) == 0);
            tick();
            if (i3 == 2'd3) begin
                check("n3 index range", int'(i3), 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
